sr2cb_phy_tx_pre: RTL and testbench

Parametrised SR2CB TX PHY framer and the successor to the fixed 7+1-byte preamble inserter. It accepts a contiguous byte stream from the SR2CB master/slave TX path and prepends a configurable preamble and SFD. The stream is delayed through an internal delay line, and after each frame the block enforces a runtime-programmable inter-packet gap. It sits directly in front of the PHY TX byte interface and adds registered outputs, short-frame handling, frame markers, a drop flag and a frame counter.

---
 rtl/sr2cb_phy_tx_pre_if.sv | 12 +
 rtl/sr2cb_phy_tx_pre.sv | 118 +++++++++++
 tb/tb_sr2cb_phy_tx_pre.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sr2cb_phy_tx_pre_if.sv
// sr2cb_phy_tx_pre_if: byte-stream handshake from the TX path and byte interface towards the PHY
interface sr2cb_phy_tx_pre_if;
   logic [7:0] rx_d;
   logic       rx_dv;
   logic       rx_dr;
   logic [7:0] tx_d;
   logic       tx_dv;
   logic       tx_sof;
   logic       tx_eof;
   modport master (output rx_d, rx_dv, input rx_dr, tx_d, tx_dv, tx_sof, tx_eof);
   modport slave  (input rx_d, rx_dv, output rx_dr, tx_d, tx_dv, tx_sof, tx_eof);
endinterface

// File: rtl/sr2cb_phy_tx_pre.sv
// sr2cb_phy_tx_pre: prepends preamble/SFD to a byte stream through a delay line and enforces an inter-packet gap
module sr2cb_phy_tx_pre #(
   parameter int         PREAMBLE_BYTES = 7,
   parameter logic [7:0] PREAMBLE_BYTE  = 8'h55,
   parameter logic [7:0] SFD_BYTE       = 8'hD5,
   parameter int         IPG_MIN        = 5,
   parameter int         IPG_WIDTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IPG_WIDTH-1:0] ipg_bytes,
   sr2cb_phy_tx_pre_if.slave    bus,
   output logic                 rx_drop,
   output logic [15:0]          frame_cnt
);
   localparam int D  = PREAMBLE_BYTES + 1;
   localparam int PW = $clog2(D);
   localparam int CW = (IPG_WIDTH > $clog2(IPG_MIN + 1)) ? IPG_WIDTH : $clog2(IPG_MIN + 1);
   typedef enum logic [1:0] {IDLE, PRE, DATA, IPG} state_t;
   state_t        state, state_nx;
   logic [PW-1:0] pre_cnt, pre_cnt_nx;
   logic [CW-1:0] ipg_cnt, ipg_cnt_nx, ipg_eff, ipg_eff_nx;
   logic [7:0]    tx_d_nx;
   logic          tx_dv_nx, sof_nx, eof_nx, dr_nx, done, acc;
   logic [7:0]    dl_d [D];
   logic [D-1:0]  dl_v;
   assign acc = bus.rx_dv && bus.rx_dr;
   // next state and next registered outputs; the tail of the delay line feeds tx once the SFD is out
   always_comb begin
      state_nx   = state;
      pre_cnt_nx = pre_cnt;
      ipg_cnt_nx = ipg_cnt;
      ipg_eff_nx = ipg_eff;
      tx_d_nx    = 8'h00;
      tx_dv_nx   = 1'b0;
      sof_nx     = 1'b0;
      eof_nx     = 1'b0;
      dr_nx      = bus.rx_dr;
      done       = 1'b0;
      case (state)
         IDLE: begin
            dr_nx = 1'b1;
            if (acc) begin
               state_nx   = PRE;
               pre_cnt_nx = '0;
               ipg_eff_nx = (CW'(ipg_bytes) < CW'(IPG_MIN)) ? CW'(IPG_MIN) : CW'(ipg_bytes);
               tx_d_nx    = PREAMBLE_BYTE;
               tx_dv_nx   = 1'b1;
               sof_nx     = 1'b1;
            end
         end
         PRE, DATA: begin
            if (!bus.rx_dv) dr_nx = 1'b0;
            if (state == PRE && pre_cnt != PW'(PREAMBLE_BYTES)) begin
               pre_cnt_nx = pre_cnt + 1'b1;
               tx_dv_nx   = 1'b1;
               tx_d_nx    = (pre_cnt == PW'(PREAMBLE_BYTES - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
            end else if (dl_v[D-1]) begin
               state_nx = DATA;
               tx_dv_nx = 1'b1;
               tx_d_nx  = dl_d[D-1];
               eof_nx   = !dl_v[D-2];
            end else begin
               state_nx   = IPG;
               ipg_cnt_nx = ipg_eff;
               done       = 1'b1;
            end
         end
         IPG: begin
            dr_nx      = 1'b0;
            ipg_cnt_nx = ipg_cnt - 1'b1;
            if (ipg_cnt == CW'(1)) begin
               state_nx = IDLE;
               dr_nx    = 1'b1;
            end
         end
      endcase
   end
   // state, counters and registered PHY-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pre_cnt    <= '0;
         ipg_cnt    <= '0;
         ipg_eff    <= '0;
         bus.tx_d   <= 8'h00;
         bus.tx_dv  <= 1'b0;
         bus.tx_sof <= 1'b0;
         bus.tx_eof <= 1'b0;
         bus.rx_dr  <= 1'b0;
         rx_drop    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_nx;
         pre_cnt    <= pre_cnt_nx;
         ipg_cnt    <= ipg_cnt_nx;
         ipg_eff    <= ipg_eff_nx;
         bus.tx_d   <= tx_d_nx;
         bus.tx_dv  <= tx_dv_nx;
         bus.tx_sof <= sof_nx;
         bus.tx_eof <= eof_nx;
         bus.rx_dr  <= dr_nx;
         rx_drop    <= bus.rx_dv && !bus.rx_dr;
         if (done) frame_cnt <= frame_cnt + 16'd1;
      end
   end
   // delay line: an accepted byte enters with valid=1, everything else enters as an empty slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_v <= '0;
         for (int i = 0; i < D; i++) dl_d[i] <= 8'h00;
      end else if (acc || state == PRE || state == DATA) begin
         dl_v    <= {dl_v[D-2:0], acc};
         dl_d[0] <= acc ? bus.rx_d : 8'h00;
         for (int i = 1; i < D; i++) dl_d[i] <= dl_d[i-1];
      end
   end
endmodule

// File: tb/tb_sr2cb_phy_tx_pre.sv
// tb_sr2cb_phy_tx_pre: randomized frames checked against a preamble/SFD/data/IPG reference model
module tb_sr2cb_phy_tx_pre;
   typedef logic [7:0] bq_t[$];
   logic        clk = 1'b0, rst_n = 1'b1, sel = 1'b0;
   logic [3:0]  ipg0 = 4'd0, ipg1 = 4'd0;
   logic        drop0, drop1;
   logic [15:0] cnt0, cnt1, exp_cnt = 16'd0;
   int          errors = 0, checks = 0, drops = 0;
   logic [7:0]  cap_d[$];
   bit          cap_sof[$], cap_eof[$];
   logic [7:0]  m_d;
   logic        m_dv, m_sof, m_eof, m_dr, m_drop;
   sr2cb_phy_tx_pre_if b0 ();
   sr2cb_phy_tx_pre_if b1 ();
   sr2cb_phy_tx_pre u_dut0 (.clk(clk), .rst_n(rst_n), .ipg_bytes(ipg0), .bus(b0), .rx_drop(drop0), .frame_cnt(cnt0));
   sr2cb_phy_tx_pre #(.PREAMBLE_BYTES(1), .SFD_BYTE(8'hAB)) u_dut1 (.clk(clk), .rst_n(rst_n), .ipg_bytes(ipg1), .bus(b1), .rx_drop(drop1), .frame_cnt(cnt1));
   always #5 clk = ~clk;
   assign m_d    = sel ? b1.tx_d   : b0.tx_d;
   assign m_dv   = sel ? b1.tx_dv  : b0.tx_dv;
   assign m_sof  = sel ? b1.tx_sof : b0.tx_sof;
   assign m_eof  = sel ? b1.tx_eof : b0.tx_eof;
   assign m_dr   = sel ? b1.rx_dr  : b0.rx_dr;
   assign m_drop = sel ? drop1     : drop0;
   // capture every transmitted byte of the selected DUT, plus drop pulses
   always @(negedge clk) begin
      if (m_dv) begin
         cap_d.push_back(m_d);
         cap_sof.push_back(m_sof);
         cap_eof.push_back(m_eof);
      end
      if (m_drop) drops++;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   // reference model: P preamble bytes, the SFD, then the frame bytes unchanged
   function automatic bq_t expect_seq(input int p, input logic [7:0] sfd, input bq_t b);
      bq_t e = {};
      repeat (p) e.push_back(8'h55);
      e.push_back(sfd);
      foreach (b[i]) e.push_back(b[i]);
      return e;
   endfunction
   function automatic int expect_gap(input int ipg);
      return (ipg < 5) ? 5 : ipg;
   endfunction
   function automatic bit seq_ok(input bq_t e);
      if (cap_d.size() != e.size()) return 1'b0;
      foreach (e[i])
         if (cap_d[i] !== e[i] || cap_sof[i] !== (i == 0) || cap_eof[i] !== (i == e.size() - 1)) return 1'b0;
      return 1'b1;
   endfunction
   function automatic bq_t rand_bytes(input int n);
      bq_t b = {};
      repeat (n) b.push_back(8'($urandom));
      return b;
   endfunction
   task automatic drive(input logic dv, input logic [7:0] d);
      if (sel) begin b1.rx_dv = dv; b1.rx_d = d; end
      else begin b0.rx_dv = dv; b0.rx_d = d; end
   endtask
   task automatic set_ipg(input logic [3:0] v);
      if (sel) ipg1 = v; else ipg0 = v;
   endtask
   task automatic send(input bq_t b);
      int t = 0;
      while (!m_dr && t < 200) begin @(negedge clk); t++; end
      if (!m_dr) begin errors++; checks++; $display("FAIL ready_timeout: rx_dr=%b required 1", m_dr); end
      foreach (b[i]) begin drive(1'b1, b[i]); @(negedge clk); end
      drive(1'b0, 8'h00);
   endtask
   task automatic finish_frame(output int gap);
      int t = 0;
      while (m_dv && t < 500) begin @(negedge clk); t++; end
      if (m_dv) begin errors++; checks++; $display("FAIL tx_dv_timeout: tx_dv=%b required 0", m_dv); end
      gap = 0;
      while (!m_dr && gap < 100) begin gap++; @(negedge clk); end
   endtask
   task automatic start_capture();
      @(negedge clk);
      cap_d.delete(); cap_sof.delete(); cap_eof.delete();
      drops = 0;
   endtask
   task automatic do_frame(input bq_t b, input logic [3:0] ipg, input logic [3:0] ipg_mid, output int gap);
      start_capture();
      set_ipg(ipg);
      send(b);
      set_ipg(ipg_mid);
      finish_frame(gap);
   endtask
   task automatic test_reset();
      sel = 1'b0;
      b0.rx_dv = 1'b0; b0.rx_d = 8'h00; b1.rx_dv = 1'b0; b1.rx_d = 8'h00;
      #3 rst_n = 1'b0;
      #1 checks++;
      if ({b0.tx_d, b0.tx_dv, b0.tx_sof, b0.tx_eof, drop0, cnt0, b0.rx_dr} !== '0) begin
         errors++; $display("FAIL reset_outputs: got tx_d=%h dv=%b cnt=%h dr=%b required all 0", b0.tx_d, b0.tx_dv, cnt0, b0.rx_dr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (b0.rx_dr !== 1'b0) begin errors++; $display("FAIL reset_dr_low: rx_dr=%b required 0", b0.rx_dr); end
      @(posedge clk); #1 checks++;
      if (b0.rx_dr !== 1'b1) begin errors++; $display("FAIL reset_dr_rise: rx_dr=%b required 1", b0.rx_dr); end
   endtask
   task automatic test_basic();
      bq_t b = '{8'h01, 8'h02, 8'h03, 8'h04};
      bq_t e = expect_seq(7, 8'hD5, b);
      int gap;
      sel = 1'b0;
      do_frame(b, 4'd5, 4'd5, gap);
      exp_cnt++;
      checks++;
      if (!seq_ok(e)) begin errors++; $display("FAIL basic_seq: got %p required %p", cap_d, e); end
      checks++;
      if (cap_d.size() != 12) begin errors++; $display("FAIL basic_len: tx_dv cycles=%0d required 12", cap_d.size()); end
      checks++;
      if (cnt0 !== exp_cnt) begin errors++; $display("FAIL basic_cnt: frame_cnt=%0d required %0d", cnt0, exp_cnt); end
      checks++;
      if (gap != 5) begin errors++; $display("FAIL basic_gap: gap=%0d required 5", gap); end
   endtask
   task automatic test_ipg();
      logic [3:0] ipg_set[3] = '{4'd2, 4'd9, 4'd9};
      logic [3:0] ipg_mid[3] = '{4'd2, 4'd9, 4'd2};
      int gap;
      sel = 1'b0;
      for (int k = 0; k < 3; k++) begin
         do_frame(rand_bytes($urandom_range(1, 6)), ipg_set[k], ipg_mid[k], gap);
         exp_cnt++;
         checks++;
         if (gap != expect_gap(int'(ipg_set[k]))) begin
            errors++; $display("FAIL ipg_%0d: gap=%0d required %0d", k, gap, expect_gap(int'(ipg_set[k])));
         end
      end
      checks++;
      if (cnt0 !== exp_cnt) begin errors++; $display("FAIL ipg_cnt: frame_cnt=%0d required %0d", cnt0, exp_cnt); end
   endtask
   task automatic test_short();
      bq_t b = '{8'hA5};
      bq_t e = expect_seq(7, 8'hD5, b);
      int gap;
      sel = 1'b0;
      do_frame(b, 4'd0, 4'd0, gap);
      exp_cnt++;
      checks++;
      if (!seq_ok(e)) begin errors++; $display("FAIL short_seq: got %p required %p", cap_d, e); end
      checks++;
      if (cap_d.size() != 9) begin errors++; $display("FAIL short_len: tx_dv cycles=%0d required 9", cap_d.size()); end
   endtask
   task automatic test_drop();
      bq_t b = rand_bytes(3);
      bq_t e = expect_seq(7, 8'hD5, b);
      int gap;
      sel = 1'b0;
      start_capture();
      set_ipg(4'd5);
      send(b);
      @(negedge clk);
      repeat (3) begin drive(1'b1, 8'($urandom)); @(negedge clk); end
      drive(1'b0, 8'h00);
      finish_frame(gap);
      exp_cnt++;
      checks++;
      if (!seq_ok(e)) begin errors++; $display("FAIL drop_seq: got %p required %p", cap_d, e); end
      checks++;
      if (drops != 3) begin errors++; $display("FAIL drop_count: rx_drop pulses=%0d required 3", drops); end
      checks++;
      if (gap != 5) begin errors++; $display("FAIL drop_gap: gap=%0d required 5", gap); end
   endtask
   task automatic test_reset_mid();
      int when[3] = '{1, 6, 10};
      int gap;
      sel = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bq_t b = rand_bytes(4);
         bq_t e = expect_seq(7, 8'hD5, b);
         start_capture();
         set_ipg(4'd5);
         send(b);
         repeat (when[k]) @(posedge clk);
         #2 rst_n = 1'b0;
         #1 checks++;
         if ({b0.tx_d, b0.tx_dv, b0.tx_sof, b0.tx_eof, drop0, cnt0, b0.rx_dr} !== '0) begin
            errors++; $display("FAIL rst_mid_%0d_outputs: tx_d=%h dv=%b cnt=%h dr=%b required all 0", k, b0.tx_d, b0.tx_dv, cnt0, b0.rx_dr);
         end
         exp_cnt = 16'd0;
         @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk); #1 checks++;
         if (b0.rx_dr !== 1'b1) begin errors++; $display("FAIL rst_mid_%0d_dr: rx_dr=%b required 1", k, b0.rx_dr); end
         do_frame(b, 4'd5, 4'd5, gap);
         exp_cnt++;
         checks++;
         if (!seq_ok(e) || cnt0 !== exp_cnt) begin
            errors++; $display("FAIL rst_mid_%0d_frame: got %p cnt=%0d required %p cnt=%0d", k, cap_d, cnt0, e, exp_cnt);
         end
      end
   endtask
   task automatic test_random();
      int gap;
      sel = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bq_t b = rand_bytes($urandom_range(1, 20));
         bq_t e = expect_seq(7, 8'hD5, b);
         logic [3:0] ipg = 4'($urandom_range(0, 15));
         do_frame(b, ipg, 4'($urandom), gap);
         exp_cnt++;
         checks++;
         if (!seq_ok(e) || gap != expect_gap(int'(ipg)) || cnt0 !== exp_cnt) begin
            errors++; $display("FAIL random_%0d: got %p gap=%0d cnt=%0d required %p gap=%0d cnt=%0d", k, cap_d, gap, cnt0, e, expect_gap(int'(ipg)), exp_cnt);
         end
      end
   endtask
   task automatic test_param();
      bq_t b = rand_bytes(3);
      bq_t e = expect_seq(1, 8'hAB, b);
      int gap;
      sel = 1'b1;
      do_frame(b, 4'd7, 4'd7, gap);
      checks++;
      if (!seq_ok(e)) begin errors++; $display("FAIL param_seq: got %p required %p", cap_d, e); end
      checks++;
      if (gap != 7 || cnt1 !== 16'd1) begin errors++; $display("FAIL param_gap_cnt: gap=%0d cnt=%0d required 7 1", gap, cnt1); end
      sel = 1'b0;
   endtask
   task automatic test_wrap();
      int gap;
      sel = 1'b0;
      @(negedge clk);
      force u_dut0.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release u_dut0.frame_cnt;
      exp_cnt = 16'hFFFF;
      do_frame(rand_bytes(2), 4'd5, 4'd5, gap);
      exp_cnt++;
      checks++;
      if (cnt0 !== exp_cnt) begin errors++; $display("FAIL wrap_cnt: frame_cnt=%h required %h", cnt0, exp_cnt); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_ipg();
      test_short();
      test_drop();
      test_reset_mid();
      test_random();
      test_param();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
